// File: rtl/qam_modulator_if.sv
// Subcarrier-in / sample-out bundle for the QAM modulator.
// The bench drives through the master modport and the DUT attaches to the slave modport.
interface qam_modulator_if #(
  parameter int maxWordIn = 6,
  parameter int W         = 16
);
  // Handshake: a sample is accepted on every clk edge where ival=1. There is
  // no ready and no backpressure. oval marks each cycle where oi/oq/strobes
  // carry a mapped sample, and oi/oq read 0 whenever oval=0.
  logic                 ival;
  logic [maxWordIn-1:0] ibit;
  logic [1:0]           index;
  logic [2:0]           index_M;
  logic                 isop;
  logic                 ieop;
  logic                 isof;

  logic                 oval;
  logic signed [W-1:0]  oi;
  logic signed [W-1:0]  oq;
  logic                 osop;
  logic                 oeop;
  logic                 osof;
  logic                 err_len;
  logic                 err_mod;

  modport master (
    output ival, ibit, index, index_M, isop, ieop, isof,
    input  oval, oi, oq, osop, oeop, osof, err_len, err_mod
  );

  modport slave (
    input  ival, ibit, index, index_M, isop, ieop, isof,
    output oval, oi, oq, osop, oeop, osof, err_len, err_mod
  );
endinterface

// File: rtl/qam_modulator.sv
// Two-stage QAM subcarrier mapper: stage 1 registers inputs and symbol bookkeeping,
// stage 2 registers the constellation point. The symbol FSM state is exported on o_dbg_state.
module qam_modulator #(
  parameter int maxWordIn = 6,
  parameter int W         = 16,
  parameter int N_SC      = 64
) (
  input  logic               clk,
  input  logic               rst,
  qam_modulator_if.slave     bus,
  output logic               o_dbg_state
);

  localparam int CW = $clog2(N_SC + 1) + 1;
  localparam logic [CW-1:0] CNT_MAX = {CW{1'b1}};

  localparam logic signed [W-1:0] L_BPSK  = W'(8192);
  localparam logic signed [W-1:0] L_QPSK  = W'(5793);
  localparam logic signed [W-1:0] L_PILOT = W'(10923);
  localparam logic signed [W-1:0] L16_1   = W'(2591);
  localparam logic signed [W-1:0] L16_3   = W'(7773);
  localparam logic signed [W-1:0] L64_1   = W'(1264);
  localparam logic signed [W-1:0] L64_3   = W'(3792);
  localparam logic signed [W-1:0] L64_5   = W'(6320);
  localparam logic signed [W-1:0] L64_7   = W'(8848);

  typedef enum logic {
    S_IDLE   = 1'b0,
    S_ACTIVE = 1'b1
  } state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic [CW-1:0]   r_cnt;
  logic [CW-1:0]   w_cnt_nxt;
  logic [CW-1:0]   w_cnt_inc;
  logic [2:0]      r_m;
  logic [2:0]      w_m_nxt;
  logic [2:0]      w_m_use;
  logic            w_err_len;

  logic                 r1_val;
  logic [maxWordIn-1:0] r1_bit;
  logic [1:0]           r1_idx;
  logic [2:0]           r1_m;
  logic                 r1_sop;
  logic                 r1_eop;
  logic                 r1_sof;
  logic                 r1_err_len;

  logic signed [W-1:0]  w_i;
  logic signed [W-1:0]  w_q;
  logic                 w_err_mod;

  logic                 r2_val;
  logic signed [W-1:0]  r2_i;
  logic signed [W-1:0]  r2_q;
  logic                 r2_sop;
  logic                 r2_eop;
  logic                 r2_sof;
  logic                 r2_err_len;
  logic                 r2_err_mod;

  // Counter saturates so an overlong symbol can never wrap back onto N_SC.
  assign w_cnt_inc = (r_cnt == CNT_MAX) ? r_cnt : r_cnt + CW'(1);

  // The start-of-symbol sample is mapped with the modulation it brings along.
  assign w_m_use = (bus.ival && bus.isop) ? bus.index_M : r_m;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_m     <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_m     <= w_m_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_m_nxt     = r_m;
    w_err_len   = 1'b0;
    if (bus.ival) begin
      if (bus.isop) begin
        w_m_nxt   = bus.index_M;
        w_cnt_nxt = CW'(1);
        w_err_len = (r_state == S_ACTIVE);
        if (bus.ieop) begin
          w_state_nxt = S_IDLE;
          w_err_len   = w_err_len | (CW'(1) != CW'(N_SC));
        end else begin
          w_state_nxt = S_ACTIVE;
        end
      end else if (r_state == S_ACTIVE) begin
        w_cnt_nxt = w_cnt_inc;
        if (bus.ieop) begin
          w_state_nxt = S_IDLE;
          w_err_len   = (w_cnt_inc != CW'(N_SC));
        end
      end else if (bus.ieop) begin
        w_err_len = 1'b1;
      end
    end
  end

  assign o_dbg_state = r_state;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r1_val     <= 1'b0;
      r1_bit     <= '0;
      r1_idx     <= '0;
      r1_m       <= '0;
      r1_sop     <= 1'b0;
      r1_eop     <= 1'b0;
      r1_sof     <= 1'b0;
      r1_err_len <= 1'b0;
    end else begin
      r1_val     <= bus.ival;
      r1_bit     <= bus.ibit;
      r1_idx     <= bus.index;
      r1_m       <= w_m_use;
      r1_sop     <= bus.isop;
      r1_eop     <= bus.ieop;
      r1_sof     <= bus.isof;
      r1_err_len <= w_err_len;
    end
  end

  function automatic logic signed [W-1:0] lvl16(input logic [1:0] g);
    case (g)
      2'b00:   return L16_3;
      2'b01:   return L16_1;
      2'b11:   return -L16_1;
      default: return -L16_3;
    endcase
  endfunction

  function automatic logic signed [W-1:0] lvl64(input logic [2:0] g);
    case (g)
      3'b000:  return L64_7;
      3'b001:  return L64_5;
      3'b011:  return L64_3;
      3'b010:  return L64_1;
      3'b110:  return -L64_1;
      3'b111:  return -L64_3;
      3'b101:  return -L64_5;
      default: return -L64_7;
    endcase
  endfunction

  always_comb begin
    w_i       = '0;
    w_q       = '0;
    w_err_mod = 1'b0;
    if (r1_val) begin
      case (r1_idx)
        2'd1: begin
          case (r1_m)
            3'd1: w_i = r1_bit[0] ? -L_BPSK : L_BPSK;
            3'd2: begin
              w_i = r1_bit[1] ? -L_QPSK : L_QPSK;
              w_q = r1_bit[0] ? -L_QPSK : L_QPSK;
            end
            3'd4: begin
              w_i = lvl16(r1_bit[3:2]);
              w_q = lvl16(r1_bit[1:0]);
            end
            3'd6: begin
              w_i = lvl64(r1_bit[5:3]);
              w_q = lvl64(r1_bit[2:0]);
            end
            default: w_err_mod = 1'b1;
          endcase
        end
        2'd2: w_i = r1_bit[0] ? -L_PILOT : L_PILOT;
        2'd3: begin
          w_i = r1_bit[1] ? -L_QPSK : L_QPSK;
          w_q = r1_bit[0] ? -L_QPSK : L_QPSK;
        end
        default: begin
          w_i = '0;
          w_q = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r2_val     <= 1'b0;
      r2_i       <= '0;
      r2_q       <= '0;
      r2_sop     <= 1'b0;
      r2_eop     <= 1'b0;
      r2_sof     <= 1'b0;
      r2_err_len <= 1'b0;
      r2_err_mod <= 1'b0;
    end else begin
      r2_val     <= r1_val;
      r2_i       <= w_i;
      r2_q       <= w_q;
      r2_sop     <= r1_sop;
      r2_eop     <= r1_eop;
      r2_sof     <= r1_sof;
      r2_err_len <= r1_err_len;
      r2_err_mod <= w_err_mod;
    end
  end

  assign bus.oval    = r2_val;
  assign bus.oi      = r2_i;
  assign bus.oq      = r2_q;
  assign bus.osop    = r2_sop;
  assign bus.oeop    = r2_eop;
  assign bus.osof    = r2_sof;
  assign bus.err_len = r2_err_len;
  assign bus.err_mod = r2_err_mod;

endmodule

// File: tb/tb_qam_modulator.sv
// Directed bench for qam_modulator: a symbol-level model predicts every output cycle,
// and hand-computed literals pin selected samples.
module tb_qam_modulator;
  localparam int MW   = 6;
  localparam int W    = 16;
  localparam int NSC  = 8;
  localparam int RW   = 2 * W + 6;
  localparam int LW   = 2 * W + 3;

  logic clk;
  logic rst;
  logic dbg_state;

  qam_modulator_if #(.maxWordIn(MW), .W(W)) bus ();

  qam_modulator #(.maxWordIn(MW), .W(W), .N_SC(NSC)) dut (
    .clk         (clk),
    .rst         (rst),
    .bus         (bus),
    .o_dbg_state (dbg_state)
  );

  int total = 0;
  int bad   = 0;

  logic [RW-1:0] exp_q[$];
  logic [LW-1:0] lit_q[$];
  logic [LW-1:0] cur_lit;

  // ---------------- clock / reset ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // ---------------- behavioural model ----------------
  int   md_len;
  int   md_m;
  logic md_in_sym;
  int   md_i;
  int   md_q;
  logic md_el;
  logic md_em;

  function automatic int gray_lvl(input int g, input int nb);
    int b;
    b = 0;
    for (int k = nb - 1; k >= 0; k--) b = (b << 1) | ((b & 1) ^ ((g >> k) & 1));
    return (2 ** nb - 1) - 2 * b;
  endfunction

  function automatic int sgn(input int bitv, input int mag);
    return (bitv != 0) ? -mag : mag;
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      exp_q.delete();
      lit_q.delete();
      md_in_sym = 1'b0;
      md_len    = 0;
      md_m      = 0;
    end else begin
      md_el = 1'b0;
      md_em = 1'b0;
      md_i  = 0;
      md_q  = 0;
      if (bus.ival) begin
        if (bus.isop) begin
          md_el     = md_in_sym;
          md_m      = int'(bus.index_M);
          md_len    = 1;
          md_in_sym = 1'b1;
          if (bus.ieop) begin
            if (md_len != NSC) md_el = 1'b1;
            md_in_sym = 1'b0;
          end
        end else if (md_in_sym) begin
          md_len++;
          if (bus.ieop) begin
            md_el     = (md_len != NSC);
            md_in_sym = 1'b0;
          end
        end else if (bus.ieop) begin
          md_el = 1'b1;
        end
        case (bus.index)
          2'd2: md_i = sgn(int'(bus.ibit[0]), 10923);
          2'd3: begin
            md_i = sgn(int'(bus.ibit[1]), 5793);
            md_q = sgn(int'(bus.ibit[0]), 5793);
          end
          2'd1: begin
            if (md_m == 1) md_i = sgn(int'(bus.ibit[0]), 8192);
            else if (md_m == 2) begin
              md_i = sgn(int'(bus.ibit[1]), 5793);
              md_q = sgn(int'(bus.ibit[0]), 5793);
            end else if (md_m == 4) begin
              md_i = gray_lvl(int'(bus.ibit[3:2]), 2) * 2591;
              md_q = gray_lvl(int'(bus.ibit[1:0]), 2) * 2591;
            end else if (md_m == 6) begin
              md_i = gray_lvl(int'(bus.ibit[5:3]), 3) * 1264;
              md_q = gray_lvl(int'(bus.ibit[2:0]), 3) * 1264;
            end else md_em = 1'b1;
          end
          default: ;
        endcase
      end
      exp_q.push_back({bus.ival, bus.isop, bus.ieop, bus.isof, md_el, md_em,
                       W'(md_i), W'(md_q)});
      lit_q.push_back(cur_lit);
    end
  end

  // ---------------- scoreboard / compare ----------------
  logic [RW-1:0] act;
  logic [RW-1:0] exp_v;
  logic [LW-1:0] lit_v;

  always @(negedge clk) begin
    act = {bus.oval, bus.osop, bus.oeop, bus.osof, bus.err_len, bus.err_mod, bus.oi, bus.oq};
    if (rst || exp_q.size() < 2) begin
      total++;
      if (act !== '0) begin
        bad++;
        $display("FAIL zero_out t=%0t got=%h want=0", $time, act);
      end
    end else begin
      exp_v = exp_q.pop_front();
      lit_v = lit_q.pop_front();
      total++;
      if (act !== exp_v) begin
        bad++;
        $display("FAIL model_cmp t=%0t got val/sop/eop/sof/el/em=%b i=%0d q=%0d want %b i=%0d q=%0d",
                 $time, act[RW-1-:6], $signed(act[2*W-1:W]), $signed(act[W-1:0]),
                 exp_v[RW-1-:6], $signed(exp_v[2*W-1:W]), $signed(exp_v[W-1:0]));
      end
      if (lit_v[LW-1]) begin
        total++;
        if ({bus.oval, bus.err_len, bus.err_mod, bus.oi, bus.oq} !== {1'b1, lit_v[LW-2:0]}) begin
          bad++;
          $display("FAIL literal t=%0t got el=%b em=%b i=%0d q=%0d want el=%b em=%b i=%0d q=%0d",
                   $time, bus.err_len, bus.err_mod, bus.oi, bus.oq, lit_v[LW-2], lit_v[LW-3],
                   $signed(lit_v[2*W-1:W]), $signed(lit_v[W-1:0]));
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic send(input logic v, input logic [MW-1:0] b, input logic [1:0] idx,
                      input logic [2:0] m, input logic sop, input logic eop, input logic sof,
                      input logic le, input int li, input int lq, input logic lel, input logic lem);
    @(negedge clk);
    bus.ival    = v;
    bus.ibit    = b;
    bus.index   = idx;
    bus.index_M = m;
    bus.isop    = sop;
    bus.ieop    = eop;
    bus.isof    = sof;
    cur_lit     = {le, lel, lem, W'(li), W'(lq)};
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) send(1'b0, '0, 2'd0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0, 1'b0, 1'b0);
  endtask

  task automatic check_state(input logic want, input string name);
    total++;
    if (dbg_state !== want) begin
      bad++;
      $display("FAIL %s got state=%b want=%b", name, dbg_state, want);
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst         = 1'b1;
    bus.ival    = 1'b0;
    bus.ibit    = '0;
    bus.index   = '0;
    bus.index_M = '0;
    bus.isop    = 1'b0;
    bus.ieop    = 1'b0;
    bus.isof    = 1'b0;
    cur_lit     = '0;
    repeat (3) @(negedge clk);
    check_state(1'b0, "reset_state");
    #2 rst = 1'b0;
    idle(2);

    // Full QPSK symbol, ibit=10 -> (-5793,+5793)
    for (int k = 0; k < NSC; k++)
      send(1'b1, 6'b000010, 2'd1, 3'd2, k == 0, k == NSC - 1, k == 0, 1'b1, -5793, 5793, 1'b0, 1'b0);
    idle(2);
    check_state(1'b0, "qpsk_end_idle");

    // 64-QAM pinned points
    for (int k = 0; k < NSC; k++) begin
      if (k % 2 == 0)
        send(1'b1, 6'b000100, 2'd1, 3'd6, k == 0, k == NSC - 1, 1'b0, 1'b1, 8848, -8848, 1'b0, 1'b0);
      else
        send(1'b1, 6'b011010, 2'd1, 3'd6, k == 0, k == NSC - 1, 1'b0, 1'b1, 3792, 1264, 1'b0, 1'b0);
    end

    // Mixed types in a 16-QAM symbol, with a gap cycle
    send(1'b1, 6'b000011, 2'd0, 3'd4, 1'b1, 1'b0, 1'b0, 1'b1, 0, 0, 1'b0, 1'b0);
    send(1'b1, 6'b000000, 2'd2, 3'd4, 1'b0, 1'b0, 1'b0, 1'b1, 10923, 0, 1'b0, 1'b0);
    send(1'b1, 6'b000001, 2'd3, 3'd4, 1'b0, 1'b0, 1'b0, 1'b1, 5793, -5793, 1'b0, 1'b0);
    check_state(1'b1, "mixed_active");
    idle(1);
    send(1'b1, 6'b000011, 2'd1, 3'd4, 1'b0, 1'b0, 1'b0, 1'b1, 7773, -2591, 1'b0, 1'b0);
    send(1'b1, 6'b001001, 2'd1, 3'd4, 1'b0, 1'b0, 1'b0, 1'b1, -7773, 2591, 1'b0, 1'b0);
    for (int k = 0; k < 3; k++)
      send(1'b1, MW'($urandom_range(0, 15)), 2'd1, 3'd4, 1'b0, k == 2, 1'b0, 1'b0, 0, 0, 1'b0, 1'b0);
    idle(1);

    // Short BPSK symbol: ieop on sample NSC-1
    for (int k = 0; k < NSC - 1; k++) begin
      if (k == NSC - 2)
        send(1'b1, 6'b000001, 2'd1, 3'd1, 1'b0, 1'b1, 1'b0, 1'b1, -8192, 0, 1'b1, 1'b0);
      else
        send(1'b1, MW'(k % 2), 2'd1, 3'd1, k == 0, 1'b0, 1'b0, 1'b1, (k % 2) ? -8192 : 8192, 0, 1'b0, 1'b0);
    end
    idle(2);
    check_state(1'b0, "short_idle");

    // Unsupported modulation latched; mid-symbol index_M change ignored
    send(1'b1, 6'b000101, 2'd1, 3'd3, 1'b1, 1'b0, 1'b0, 1'b1, 0, 0, 1'b0, 1'b1);
    for (int k = 1; k < NSC; k++) begin
      if (k == 3)
        send(1'b1, 6'b000001, 2'd2, 3'd4, 1'b0, 1'b0, 1'b0, 1'b1, -10923, 0, 1'b0, 1'b0);
      else
        send(1'b1, MW'($urandom_range(0, 63)), 2'd1, 3'd4, 1'b0, k == NSC - 1, 1'b0, 1'b1, 0, 0, 1'b0, 1'b1);
    end

    // Reset in the middle of a symbol, then a clean symbol
    for (int k = 0; k < 3; k++)
      send(1'b1, 6'b000011, 2'd1, 3'd2, k == 0, 1'b0, 1'b0, 1'b0, 0, 0, 1'b0, 1'b0);
    idle(1);
    #2 rst = 1'b1;
    repeat (3) @(negedge clk);
    check_state(1'b0, "mid_reset_state");
    #2 rst = 1'b0;
    idle(1);
    for (int k = 0; k < NSC; k++)
      send(1'b1, 6'b000001, 2'd1, 3'd2, k == 0, k == NSC - 1, k == 0, 1'b1, 5793, -5793, 1'b0, 1'b0);

    // ieop while idle; idle sample mapped with last modulation
    send(1'b1, 6'b000011, 2'd1, 3'd0, 1'b0, 1'b1, 1'b0, 1'b1, -5793, -5793, 1'b1, 1'b0);
    send(1'b1, 6'b000000, 2'd1, 3'd0, 1'b0, 1'b0, 1'b0, 1'b1, 5793, 5793, 1'b0, 1'b0);
    // One-sample symbol
    send(1'b1, 6'b000001, 2'd1, 3'd1, 1'b1, 1'b1, 1'b0, 1'b1, -8192, 0, 1'b1, 1'b0);
    idle(1);
    check_state(1'b0, "one_sample_idle");

    // Restart: isop while active
    for (int k = 0; k < 3; k++)
      send(1'b1, MW'($urandom_range(0, 3)), 2'd1, 3'd2, k == 0, 1'b0, 1'b0, 1'b0, 0, 0, 1'b0, 1'b0);
    send(1'b1, 6'b100100, 2'd1, 3'd6, 1'b1, 1'b0, 1'b0, 1'b1, -8848, -8848, 1'b1, 1'b0);
    for (int k = 1; k < NSC - 1; k++)
      send(1'b1, MW'($urandom_range(0, 63)), 2'd1, 3'd2, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0, 1'b0, 1'b0);
    send(1'b1, 6'b011010, 2'd1, 3'd2, 1'b0, 1'b1, 1'b0, 1'b1, 3792, 1264, 1'b0, 1'b0);

    // Overlong symbol
    for (int k = 0; k < NSC + 1; k++)
      send(1'b1, 6'b000000, 2'd1, 3'd2, k == 0, k == NSC, 1'b0, 1'b1, 5793, 5793, k == NSC, 1'b0);
    idle(4);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/qam_modulator.md
QAM_MODULATOR -- requirements
Module: qam_modulator

Interface
REQ-001 Parameter maxWordIn, 6, width of input bit group (max bits per subcarrier).
REQ-002 Parameter W, 16, width of signed two's-complement I/Q outputs.
REQ-003 Parameter N_SC, fftsize (from parameters.vh), subcarriers per symbol.
REQ-004 clk  in  1  single clock for all logic.
REQ-005 rst  in  1  asynchronous reset, active-high.
REQ-006 ival  in  1  input subcarrier valid.
REQ-007 ibit  in  maxWordIn  bit group for the current subcarrier.
REQ-008 index  in  2  subcarrier type: 0 null, 1 data, 2 pilot, 3 preamble.
REQ-009 index_M  in  3  bits per data subcarrier: 1 BPSK, 2 QPSK, 4 16-QAM, 6 64-QAM.
REQ-010 isop / ieop / isof  in  1 each  start-of-symbol / end-of-symbol / start-of-frame strobes.
REQ-011 oval  out  1  output sample valid.
REQ-012 oi, oq  out  W each  signed I and Q sample.
REQ-013 osop / oeop / osof  out  1 each  delayed framing strobes.
REQ-014 err_len  out  1  one-cycle pulse: symbol length is not N_SC.
REQ-015 err_mod  out  1  one-cycle pulse: unsupported index_M on a data subcarrier.

Function
REQ-016 Two-stage pipeline: stage 1 registers inputs and the latched modulation; stage 2 registers the mapped I/Q. Fixed latency 2 cycles from ival to oval.
REQ-017 osop, oeop, osof and oval are the inputs delayed exactly 2 cycles, aligned with oi/oq.
REQ-018 FSM states IDLE and ACTIVE. IDLE->ACTIVE on ival&isop. ACTIVE->IDLE on ival&ieop. ival&isop&ieop in the same cycle is a one-sample symbol: stay in IDLE and check the length.
REQ-019 index_M is latched into m_reg on ival&isop and held for the whole symbol. Changes of index_M mid-symbol are ignored.
REQ-020 The sample counter clears to 1 on ival&isop and increments on every other ival while ACTIVE.
REQ-021 On ival&ieop, err_len pulses when the final count (including the ieop sample) is not N_SC. The pulse appears aligned with oeop.
REQ-022 ival&isop while ACTIVE raises err_len (aligned with that sample's osop), restarts the count at 1 and relatches m_reg.
REQ-023 ival&ieop while IDLE without isop raises err_len and leaves the FSM in IDLE.
REQ-024 Samples with ival while IDLE and no isop are still mapped and output, using the last m_reg.
REQ-025 Null (index 0): oi=oq=0.
REQ-026 Preamble (index 3): I sign from ibit[1], Q sign from ibit[0]; 0 maps to +5793, 1 maps to -5793.
REQ-027 Pilot (index 2): oi is +10923 when ibit[0]=0 and -10923 when ibit[0]=1; oq=0.
REQ-028 BPSK: oi is +8192 when ibit[0]=0 and -8192 when ibit[0]=1; oq=0.
REQ-029 QPSK: I from ibit[1], Q from ibit[0]; 0 maps to +5793, 1 maps to -5793.
REQ-030 16-QAM: I from ibit[3:2], Q from ibit[1:0]. Gray levels 00 +3, 01 +1, 11 -1, 10 -3, with unit 2591 (so 3 = 7773).
REQ-031 64-QAM: I from ibit[5:3], Q from ibit[2:0]. Gray levels 000 +7, 001 +5, 011 +3, 010 +1, 110 -1, 111 -3, 101 -5, 100 -7, with unit 1264 (so 7 = 8848, 5 = 6320, 3 = 3792).
REQ-032 Data with any other m_reg value: oi=oq=0, and err_mod pulses aligned with that output sample.
REQ-033 All level constants are exact W-bit signed values; no rounding or saturation logic is required.
REQ-034 With ival=0, the pipeline advances with oval=0; oi/oq are driven to 0 whenever oval=0.

Reset
REQ-035 While rst is high (asynchronous assert), all outputs are 0, the FSM is IDLE, the counter is 0 and m_reg is 0.
REQ-036 Release of rst takes effect on the next clk edge. The first valid output appears 2 cycles after the first post-reset ival.
REQ-037 Reset asserted mid-symbol discards the partial symbol without raising err_len.

Verification
REQ-038 Full QPSK symbol: N_SC samples, index=1, index_M=2, ibit=2'b10 -> each output oi=-5793, oq=+5793; osop on the first and oeop on the last, 2 cycles late; err_len=0.
REQ-039 64-QAM: ibit=6'b000100 -> oi=+8848, oq=-8848; ibit=6'b011010 -> oi=+3792, oq=+1264.
REQ-040 Mixed types in one symbol: index 0 -> (0,0); index 2 with ibit 0 -> (+10923,0); index 3 with ibit 2'b01 -> (+5793,-5793).
REQ-041 Short symbol: ieop on sample N_SC-1 -> err_len single pulse coincident with oeop, FSM returns to IDLE.
REQ-042 index_M=3 latched at isop, data subcarrier -> oi=oq=0 with err_mod pulse; index_M changed to 4 mid-symbol -> no effect on mapping.
REQ-043 rst pulsed mid-symbol, then a clean N_SC symbol -> outputs 0 during reset, no err_len, and the next symbol is mapped correctly with latency 2.
